pmu_counters: RTL and testbench
===============================

Name: pmu_counters

Overview:
- Bank of N free-running event counters in the PMU, one per selectable event line.
- Feeds the quota-consumption stage through counter_values_o.
- Software configures it through a single-beat write port from the PMU register wrapper.
- Detects counter wrap-around, keeps sticky per-counter overflow flags and raises a maskable overflow interrupt.

Parameters:
- REG_WIDTH, 32, width of each counter.
- N_COUNTERS, 9, number of counters and event lines.
- IDX_W, $clog2(N_COUNTERS) (localparam), counter index width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- softrst_i  in  1  synchronous soft reset from configuration registers, active-high.
- en_i  in  1  global counting enable.
- events_i  in  N_COUNTERS  one event pulse per counter per cycle.
- we_i  in  1  software write strobe, single cycle.
- waddr_i  in  IDX_W  counter index to write.
- wdata_i  in  REG_WIDTH  value to load.
- ovf_mask_i  in  N_COUNTERS  per-counter overflow interrupt enable.
- ovf_clr_i  in  N_COUNTERS  write-1-to-clear strobes for the sticky overflow flags.
- counter_values_o  out  REG_WIDTH x [0:N_COUNTERS-1]  current counter values (unpacked array).
- ovf_flags_o  out  N_COUNTERS  sticky overflow flags.
- intr_ovf_o  out  1  overflow interrupt.

Behaviour:
- Reset (rstn_i low, asynchronous): all counters 0, ovf_flags_o 0, intr_ovf_o 0.
- softrst_i high: same clearing as reset on the next edge. It overrides every other input in that cycle.
- Counter priority per counter k, evaluated each cycle, highest first:
  1. softrst_i: counter k becomes 0.
  2. we_i and waddr_i==k: counter k loads wdata_i. A coincident event is dropped.
  3. en_i and events_i[k]: counter k becomes counter k + 1.
  4. Otherwise: hold.
- Latency: an event at edge t is visible on counter_values_o after edge t. Outputs come straight from flops, with no combinational path from inputs.
- Wrap-around: increment from all-ones gives 0 and sets ovf_flags_o[k] on the same edge. Counting continues.
- A software write of all-ones never sets the flag by itself. The following increment does set it.
- waddr_i >= N_COUNTERS: the write is ignored with no side effects.
- Overflow flags: sticky until cleared.
  - ovf_clr_i[k] clears flag k.
  - If a clear and a new overflow hit the same flag in the same cycle, the set wins and the flag stays 1.
  - softrst_i clears all flags.
- Interrupt: intr_ovf_o is registered and equals |(ovf_flags_o & ovf_mask_i) from the previous cycle, so there is a one-cycle lag after a flag changes.
  - Changing the mask while a flag is pending updates intr_ovf_o one cycle later.
- en_i low freezes counting. Software writes and overflow flag clears still take effect.
- Events are level-sampled each cycle. A multi-cycle high event counts once per cycle.

Decomposition:
- Shared package pmu_pkg holds:
  - The default REG_WIDTH and N_COUNTERS constants shared with the quota stage.
  - typedef counter_t (logic [REG_WIDTH-1:0]).
  - A helper function for the index width.
- One sub-module, pmu_counter_cell: a single counter with its priority logic, increment, wrap detection and sticky flag. It is instantiated N_COUNTERS times in a generate loop.
- The top level holds only the write-address decode and the interrupt reduction register.

Test Plan:
1. Reset, then en_i=1 and events_i[0] high for 5 cycles -> counter_values_o[0]=5, all other counters 0, intr_ovf_o=0.
2. Write 0xFFFFFFFE to counter 3, ovf_mask_i[3]=1, then 2 events -> counter 3 goes 0xFFFFFFFF then 0, ovf_flags_o[3]=1 on the wrap edge, intr_ovf_o=1 one cycle later.
3. Same cycle: we_i to counter 2 with 0x100 and events_i[2]=1 -> counter 2 = 0x100 exactly (event dropped).
4. Same cycle: ovf_clr_i[3]=1 and a new wrap of counter 3 -> flag remains 1. A clear on a later cycle alone -> flag 0 and intr_ovf_o drops one cycle later.
5. en_i=0 with events toggling for 10 cycles -> counters unchanged. A write with waddr_i=N_COUNTERS -> no counter changes.
6. Counters at nonzero values with a flag set, then softrst_i pulse -> all counters 0, flags 0, intr_ovf_o 0. Then assert rstn_i asynchronously mid-count -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pmu_pkg.sv
// Shared PMU definitions: default counter geometry (also used by the quota
// stage), the counter value type and the index-width helper.
package pmu_pkg;

    // Default counter width and number of counted event lines.
    localparam int PMU_REG_WIDTH  = 32;
    localparam int PMU_N_COUNTERS = 9;

    // One counter value at the default width.
    typedef logic [PMU_REG_WIDTH-1:0] counter_t;

    // Width of an index able to address n counters. A bank of one counter
    // still gets a one-bit address so the write port never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pmu_pkg

// File: rtl/pmu_counter_cell.sv
// A single PMU event counter: soft reset / software load / event increment
// priority, wrap-around detection and the sticky overflow flag.
module pmu_counter_cell
    import pmu_pkg::*;
#(
    parameter int REG_WIDTH = PMU_REG_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 softrst_i,
    input  logic                 en_i,
    input  logic                 event_i,
    input  logic                 load_i,
    input  logic [REG_WIDTH-1:0] wdata_i,
    input  logic                 ovf_clr_i,
    output logic [REG_WIDTH-1:0] count_o,
    output logic                 ovf_o
);

    logic [REG_WIDTH-1:0] count_q, count_d;
    logic                 flag_q, flag_d;
    logic [REG_WIDTH-1:0] count_inc;
    logic                 carry;
    logic                 wrap;

    // Increment with carry-out; the carry marks the all-ones -> zero wrap.
    assign {carry, count_inc} = {1'b0, count_q} + {{REG_WIDTH{1'b0}}, 1'b1};

    // Next counter value and wrap strobe by priority: soft reset, load, event.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        count_d = count_q;
        wrap    = 1'b0;
        if (softrst_i) begin
            count_d = '0;
        end else if (load_i) begin
            // A load wins over a coincident event, and loading all-ones is
            // not an overflow: only a real increment can wrap.
            count_d = wdata_i;
        end else if (en_i && event_i) begin
            count_d = count_inc;
            wrap    = carry;
        end
    end

    // Sticky overflow flag: a new wrap beats a simultaneous clear.
    always_comb begin
        flag_d = flag_q;
        if (softrst_i) begin
            flag_d = 1'b0;
        end else if (wrap) begin
            flag_d = 1'b1;
        end else if (ovf_clr_i) begin
            flag_d = 1'b0;
        end
    end

    // Counter and flag state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = flag_q;

endmodule : pmu_counter_cell

// File: rtl/pmu_counters.sv
// Bank of free-running PMU event counters with sticky overflow flags and a
// registered, maskable overflow interrupt. The top level decodes the
// software write address and reduces the masked flags into the interrupt;
// everything per-counter lives in pmu_counter_cell.
module pmu_counters
    import pmu_pkg::*;
#(
    parameter  int REG_WIDTH  = PMU_REG_WIDTH,
    parameter  int N_COUNTERS = PMU_N_COUNTERS,
    localparam int IDX_W      = idx_width(N_COUNTERS)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  softrst_i,
    input  logic                  en_i,
    input  logic [N_COUNTERS-1:0] events_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [REG_WIDTH-1:0]  wdata_i,
    input  logic [N_COUNTERS-1:0] ovf_mask_i,
    input  logic [N_COUNTERS-1:0] ovf_clr_i,
    output logic [REG_WIDTH-1:0]  counter_values_o [0:N_COUNTERS-1],
    output logic [N_COUNTERS-1:0] ovf_flags_o,
    output logic                  intr_ovf_o
);

    logic [N_COUNTERS-1:0] load_vec;
    logic                  intr_q, intr_d;

    // One-hot load strobes from the write port. Addresses at or beyond
    // N_COUNTERS match no counter, so such writes vanish without effect.
    always_comb begin
        load_vec = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (we_i && (waddr_i == IDX_W'(k))) begin
                load_vec[k] = 1'b1;
            end
        end
    end

    // Counter cells, one per event line.
    for (genvar g = 0; g < N_COUNTERS; g++) begin : g_cell
        pmu_counter_cell #(
            .REG_WIDTH (REG_WIDTH)
        ) u_cell (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .softrst_i (softrst_i),
            .en_i      (en_i),
            .event_i   (events_i[g]),
            .load_i    (load_vec[g]),
            .wdata_i   (wdata_i),
            .ovf_clr_i (ovf_clr_i[g]),
            .count_o   (counter_values_o[g]),
            .ovf_o     (ovf_flags_o[g])
        );
    end

    // Interrupt follows the masked flags of the current cycle one edge later;
    // a soft reset clears it together with the flags.
    always_comb begin
        intr_d = |(ovf_flags_o & ovf_mask_i);
        if (softrst_i) begin
            intr_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= intr_d;
        end
    end

    assign intr_ovf_o = intr_q;

endmodule : pmu_counters

// File: tb/tb_pmu_counters.sv
// Self-checking bench for pmu_counters: a cycle model built from the
// behavioural rules, compared every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_pmu_counters;
    import pmu_pkg::*;

    localparam int RW    = PMU_REG_WIDTH;
    localparam int NC    = PMU_N_COUNTERS;
    localparam int IW    = idx_width(NC);
    localparam longint unsigned MODULUS = 64'd1 << RW;

    logic          clk;
    logic          rstn;
    logic          softrst;
    logic          en;
    logic [NC-1:0] events;
    logic          we;
    logic [IW-1:0] waddr;
    logic [RW-1:0] wdata;
    logic [NC-1:0] ovf_mask;
    logic [NC-1:0] ovf_clr;
    logic [RW-1:0] counter_values [0:NC-1];
    logic [NC-1:0] ovf_flags;
    logic          intr_ovf;

    int checks = 0;
    int errors = 0;

    pmu_counters dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .softrst_i        (softrst),
        .en_i             (en),
        .events_i         (events),
        .we_i             (we),
        .waddr_i          (waddr),
        .wdata_i          (wdata),
        .ovf_mask_i       (ovf_mask),
        .ovf_clr_i        (ovf_clr),
        .counter_values_o (counter_values),
        .ovf_flags_o      (ovf_flags),
        .intr_ovf_o       (intr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as plain integers modulo 2^RW.
    longint unsigned m_cnt [NC];
    bit [NC-1:0]     m_flag;
    bit              m_intr;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_flag = '0;
            m_intr = 1'b0;
        end else begin
            m_intr = softrst ? 1'b0 : |(m_flag & ovf_mask);
            for (int k = 0; k < NC; k++) begin
                bit wrapped;
                wrapped = 1'b0;
                if (softrst) begin
                    m_cnt[k]  = 0;
                    m_flag[k] = 1'b0;
                end else begin
                    if (we && int'(waddr) == k) begin
                        m_cnt[k] = longint'(wdata);
                    end else if (en && events[k]) begin
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == MODULUS) begin
                            m_cnt[k] = 0;
                            wrapped  = 1'b1;
                        end
                    end
                    m_flag[k] = wrapped || (m_flag[k] && !ovf_clr[k]);
                end
            end
        end
    end

    // Every-cycle comparison, shortly after the active edge.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NC; k++) begin
            check($sformatf("model_cnt%0d", k), 64'(counter_values[k]), 64'(m_cnt[k]));
        end
        check("model_flags", 64'(ovf_flags), 64'(m_flag));
        check("model_intr", 64'(intr_ovf), 64'(m_intr));
    end

    task automatic idle();
        softrst = 1'b0;
        events  = '0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        ovf_clr = '0;
    endtask

    task automatic write(input int addr, input logic [RW-1:0] data);
        @(negedge clk);
        idle();
        we    = 1'b1;
        waddr = IW'(addr);
        wdata = data;
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        en       = 1'b0;
        ovf_mask = '0;
        idle();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("reset_cnt0", 64'(counter_values[0]), 64'd0);
        check("reset_flags", 64'(ovf_flags), 64'd0);
        check("reset_intr", 64'(intr_ovf), 64'd0);

        // 1: five cycles of event 0.
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            events = 9'b0_0000_0001;
        end
        @(negedge clk);
        idle();
        check("t1_cnt0", 64'(counter_values[0]), 64'd5);
        check("t1_cnt4", 64'(counter_values[4]), 64'd0);
        check("t1_intr", 64'(intr_ovf), 64'd0);

        // 2: wrap of counter 3 with its interrupt unmasked.
        ovf_mask = 9'b0_0000_1000;
        write(3, 32'hFFFF_FFFE);
        check("t2_loaded", 64'(counter_values[3]), 64'hFFFF_FFFE);
        events = 9'b0_0000_1000;
        @(negedge clk);
        check("t2_allones", 64'(counter_values[3]), 64'hFFFF_FFFF);
        check("t2_noflag", 64'(ovf_flags[3]), 64'd0);
        @(negedge clk);
        idle();
        check("t2_wrapped", 64'(counter_values[3]), 64'd0);
        check("t2_flag", 64'(ovf_flags[3]), 64'd1);
        check("t2_intr_lag", 64'(intr_ovf), 64'd0);
        @(negedge clk);
        check("t2_intr", 64'(intr_ovf), 64'd1);

        // 3: load and event on the same counter in the same cycle.
        @(negedge clk);
        we     = 1'b1;
        waddr  = 4'd2;
        wdata  = 32'h100;
        events = 9'b0_0000_0100;
        @(negedge clk);
        idle();
        check("t3_load_wins", 64'(counter_values[2]), 64'h100);

        // 4: clear coinciding with a new wrap, then a clear alone.
        write(3, 32'hFFFF_FFFF);
        check("t4_load_no_flag_change", 64'(ovf_flags), 64'h8);
        events  = 9'b0_0000_1000;
        ovf_clr = 9'b0_0000_1000;
        @(negedge clk);
        idle();
        check("t4_set_wins", 64'(ovf_flags[3]), 64'd1);
        check("t4_wrap_cnt", 64'(counter_values[3]), 64'd0);
        ovf_clr = 9'b0_0000_1000;
        @(negedge clk);
        idle();
        check("t4_cleared", 64'(ovf_flags[3]), 64'd0);
        check("t4_intr_still", 64'(intr_ovf), 64'd1);
        @(negedge clk);
        check("t4_intr_drop", 64'(intr_ovf), 64'd0);

        // 5: counting frozen, out-of-range write ignored.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            events = (i % 2 == 0) ? 9'h1FF : 9'h0AA;
        end
        @(negedge clk);
        idle();
        check("t5_frozen0", 64'(counter_values[0]), 64'd5);
        check("t5_frozen2", 64'(counter_values[2]), 64'h100);
        write(NC, 32'hDEAD_BEEF);
        check("t5_oor0", 64'(counter_values[0]), 64'd5);
        check("t5_oor8", 64'(counter_values[8]), 64'd0);

        // 6: soft reset with counters and a pending flag, then async reset.
        ovf_mask = 9'b0_0000_0010;
        write(1, 32'hFFFF_FFFF);
        en     = 1'b1;
        events = 9'b0_0000_0010;
        @(negedge clk);
        idle();
        check("t6_flag1", 64'(ovf_flags), 64'h2);
        @(negedge clk);
        check("t6_intr", 64'(intr_ovf), 64'd1);
        softrst = 1'b1;
        events  = 9'h1FF;
        we      = 1'b1;
        waddr   = 4'd0;
        wdata   = 32'h7;
        @(negedge clk);
        idle();
        check("t6_sr_cnt0", 64'(counter_values[0]), 64'd0);
        check("t6_sr_cnt2", 64'(counter_values[2]), 64'd0);
        check("t6_sr_flags", 64'(ovf_flags), 64'd0);
        check("t6_sr_intr", 64'(intr_ovf), 64'd0);
        events = 9'h1FF;
        repeat (3) @(negedge clk);
        check("t6_counting", 64'(counter_values[5]), 64'd3);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("t6_async_cnt5", 64'(counter_values[5]), 64'd0);
        check("t6_async_flags", 64'(ovf_flags), 64'd0);
        check("t6_async_intr", 64'(intr_ovf), 64'd0);
        @(negedge clk);
        idle();
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pmu_counters
